// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial two's-complement subtractor, one bit per clock, LSB first
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             overflow
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] r_sr;
   logic             carry;
   logic [CW-1:0]    count;

   logic             nb;
   logic             s;
   logic             carry_nx;
   logic             last_bit;
   logic             accept;

   // Full-adder slice fed with ~b; carry is seeded with 1 on accept.
   always_comb begin
      nb       = ~b_sr[0];
      s        = a_sr[0] ^ nb ^ carry;
      carry_nx = (a_sr[0] & nb) | (a_sr[0] & carry) | (nb & carry);
      last_bit = (count == LAST);
      accept   = (state == IDLE) && start;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start)    state_nx = SHIFT;
         SHIFT:   if (last_bit) state_nx = IDLE;
         default:               state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   assign busy = (state == SHIFT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr       <= '0;
         b_sr       <= '0;
         r_sr       <= '0;
         carry      <= 1'b0;
         count      <= '0;
         done       <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= 1'b1;
            count <= '0;
         end else if (state == SHIFT) begin
            a_sr  <= a_sr >> 1;
            b_sr  <= b_sr >> 1;
            r_sr  <= {s, r_sr[WIDTH-1:1]};
            carry <= carry_nx;
            count <= count + 1'b1;
            // On the last bit the shifted-out operand bits are the original MSBs.
            if (last_bit) begin
               done       <= 1'b1;
               diff       <= {s, r_sr[WIDTH-1:1]};
               borrow_out <= ~carry_nx;
               overflow   <= (a_sr[0] != b_sr[0]) && (s != a_sr[0]);
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and random checks of serial_subtractor at WIDTH 8 and 3
module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       busy8, done8, borrow8, ovf8;
   logic [7:0] diff8;
   logic       start3 = 1'b0;
   logic [2:0] a3 = '0;
   logic [2:0] b3 = '0;
   logic       busy3, done3, borrow3, ovf3;
   logic [2:0] diff3;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8), .overflow(ovf8)
   );

   serial_subtractor #(.WIDTH(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3),
      .busy(busy3), .done(done3), .diff(diff3), .borrow_out(borrow3), .overflow(ovf3)
   );

   // Called at the negedge of the accept cycle; returns at the negedge of the done cycle.
   task automatic wait_done8(output int busy_cycles, output bit timed_out);
      busy_cycles = 0;
      timed_out   = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (done8) begin
            timed_out = 1'b0;
            break;
         end
         if (busy8) busy_cycles++;
         @(negedge clk);
      end
   endtask

   task automatic wait_done3(output int busy_cycles, output bit timed_out);
      busy_cycles = 0;
      timed_out   = 1'b1;
      for (int i = 0; i < 30; i++) begin
         if (done3) begin
            timed_out = 1'b0;
            break;
         end
         if (busy3) busy_cycles++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      total++;
      if ({busy8, done8, diff8, borrow8, ovf8} !== 12'h000) begin
         $display("FAIL reset_in: busy=%b done=%b diff=%h borrow=%b ovf=%b want all 0",
                  busy8, done8, diff8, borrow8, ovf8);
      end else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      total++;
      if ({busy8, done8, diff8, borrow8, ovf8, busy3, done3, diff3, borrow3, ovf3} !== 19'h0) begin
         $display("FAIL reset_idle: busy8=%b done8=%b diff8=%h busy3=%b done3=%b diff3=%h want 0",
                  busy8, done8, diff8, busy3, done3, diff3);
      end else passed++;
   endtask

   task automatic test_subtract();
      logic [7:0] va [6] = '{8'h35, 8'h12, 8'h80, 8'h7F, 8'hA5, 8'h00};
      logic [7:0] vb [6] = '{8'h12, 8'h35, 8'h01, 8'hFF, 8'hA5, 8'h01};
      logic [7:0] vd [6] = '{8'h23, 8'hDD, 8'h7F, 8'h80, 8'h00, 8'hFF};
      logic       vbr[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic       vov[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      int bc;
      bit to;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         a8 = va[i]; b8 = vb[i]; start8 = 1'b1;
         @(negedge clk);
         start8 = 1'b0;
         wait_done8(bc, to);
         total++;
         if (to || bc != 8) begin
            $display("FAIL latency_%0d: busy_cycles=%0d timeout=%0b want 8 busy cycles then done", i, bc, to);
         end else passed++;
         total++;
         if ({diff8, borrow8, ovf8} !== {vd[i], vbr[i], vov[i]}) begin
            $display("FAIL sub_%0d: %h-%h got diff=%h borrow=%b ovf=%b want diff=%h borrow=%b ovf=%b",
                     i, va[i], vb[i], diff8, borrow8, ovf8, vd[i], vbr[i], vov[i]);
         end else passed++;
         @(negedge clk);
         total++;
         if (done8 !== 1'b0 || busy8 !== 1'b0 || diff8 !== vd[i]) begin
            $display("FAIL pulse_%0d: done=%b busy=%b diff=%h want done=0 busy=0 diff=%h",
                     i, done8, busy8, diff8, vd[i]);
         end else passed++;
      end
   endtask

   task automatic test_robustness();
      int dones = 0;
      logic [7:0] cap = '0;
      @(negedge clk);
      a8 = 8'h40; b8 = 8'h10; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      for (int c = 1; c < 24; c++) begin
         if (done8) begin
            dones++;
            cap = diff8;
         end
         if (c == 3) begin
            a8 = 8'hFF; b8 = 8'h01; start8 = 1'b1;
         end else begin
            start8 = 1'b0;
         end
         @(negedge clk);
      end
      total++;
      if (dones != 1 || cap !== 8'h30) begin
         $display("FAIL ignore_busy: dones=%0d diff=%h want dones=1 diff=30", dones, cap);
      end else passed++;
   endtask

   task automatic test_back_to_back();
      int bc;
      bit to;
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      wait_done8(bc, to);
      total++;
      if (to || diff8 !== 8'h0F) begin
         $display("FAIL b2b_first: diff=%h timeout=%0b want diff=0f", diff8, to);
      end else passed++;
      a8 = 8'h05; b8 = 8'h03; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'hEE; b8 = 8'h77;
      total++;
      if (busy8 !== 1'b1 || done8 !== 1'b0) begin
         $display("FAIL b2b_accept: busy=%b done=%b want busy=1 done=0", busy8, done8);
      end else passed++;
      wait_done8(bc, to);
      total++;
      if (to || bc != 8 || {diff8, borrow8, ovf8} !== {8'h02, 1'b0, 1'b0}) begin
         $display("FAIL b2b_second: busy_cycles=%0d timeout=%0b diff=%h borrow=%b ovf=%b want 8 02 0 0",
                  bc, to, diff8, borrow8, ovf8);
      end else passed++;
   endtask

   task automatic test_async_reset();
      int dones = 0;
      int bc;
      bit to;
      @(negedge clk);
      a8 = 8'h50; b8 = 8'h20; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      repeat (4) @(negedge clk);
      #3 rst_n = 1'b0;
      #1;
      total++;
      if ({busy8, done8, diff8, borrow8, ovf8} !== 12'h000) begin
         $display("FAIL async_reset: busy=%b done=%b diff=%h borrow=%b ovf=%b want all 0",
                  busy8, done8, diff8, borrow8, ovf8);
      end else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 14; c++) begin
         if (done8 || busy8) dones++;
         @(negedge clk);
      end
      total++;
      if (dones != 0) begin
         $display("FAIL reset_abort: active_cycles=%0d want 0", dones);
      end else passed++;
      a8 = 8'h09; b8 = 8'h04; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      wait_done8(bc, to);
      total++;
      if (to || {diff8, borrow8, ovf8} !== {8'h05, 1'b0, 1'b0}) begin
         $display("FAIL after_reset: diff=%h borrow=%b ovf=%b timeout=%0b want 05 0 0", diff8, borrow8, ovf8, to);
      end else passed++;
   endtask

   task automatic test_random8();
      int ra, rb, sa, sb, sd, bc;
      bit to;
      logic [7:0] ed;
      logic eb, eo;
      int errs = 0;
      for (int n = 0; n < 1000; n++) begin
         ra = int'($urandom_range(0, 255));
         rb = int'($urandom_range(0, 255));
         sa = (ra >= 128) ? ra - 256 : ra;
         sb = (rb >= 128) ? rb - 256 : rb;
         sd = sa - sb;
         ed = 8'((ra - rb + 256) % 256);
         eb = (ra < rb);
         eo = (sd > 127) || (sd < -128);
         @(negedge clk);
         a8 = 8'(ra); b8 = 8'(rb); start8 = 1'b1;
         @(negedge clk);
         start8 = 1'b0;
         wait_done8(bc, to);
         total++;
         if (to || {diff8, borrow8, ovf8} !== {ed, eb, eo}) begin
            if (errs < 5) $display("FAIL rand8: %h-%h got diff=%h borrow=%b ovf=%b timeout=%0b want %h %b %b",
                                   ra[7:0], rb[7:0], diff8, borrow8, ovf8, to, ed, eb, eo);
            errs++;
         end else passed++;
      end
   endtask

   task automatic test_random3();
      int ra, rb, sa, sb, sd, bc;
      bit to;
      logic [2:0] ed;
      logic eb, eo;
      int errs = 0;
      for (int n = 0; n < 1000; n++) begin
         ra = int'($urandom_range(0, 7));
         rb = int'($urandom_range(0, 7));
         sa = (ra >= 4) ? ra - 8 : ra;
         sb = (rb >= 4) ? rb - 8 : rb;
         sd = sa - sb;
         ed = 3'((ra - rb + 8) % 8);
         eb = (ra < rb);
         eo = (sd > 3) || (sd < -4);
         @(negedge clk);
         a3 = 3'(ra); b3 = 3'(rb); start3 = 1'b1;
         @(negedge clk);
         start3 = 1'b0;
         wait_done3(bc, to);
         total++;
         if (to || bc != 3 || {diff3, borrow3, ovf3} !== {ed, eb, eo}) begin
            if (errs < 5) $display("FAIL rand3: %0d-%0d got diff=%0d borrow=%b ovf=%b busy_cycles=%0d timeout=%0b want %0d %b %b",
                                   ra, rb, diff3, borrow3, ovf3, bc, to, ed, eb, eo);
            errs++;
         end else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_subtract();
      test_robustness();
      test_back_to_back();
      test_async_reset();
      test_random8();
      test_random3();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
